// File: rtl/otter_run_controller.sv
// Run/check controller for OTTER: sources CPU_RST and snoops the IOBUS for an end-of-test write.
// Optional write counter (WR_COUNT) enabled by defining OTTER_RUN_WRCOUNT_EN.
module otter_run_controller #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned MAX_CYCLES = 50,
  parameter logic [31:0] HALT_ADDR  = 32'h1100_00F0,
  parameter logic [31:0] PASS_VALUE = 32'h0000_0001,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  input  logic             IOBUS_WR,
  output logic             CPU_RST,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             FAIL,
  output logic             TIMEOUT,
  output logic [31:0]      RESULT,
`ifdef OTTER_RUN_WRCOUNT_EN
  output logic [15:0]      WR_COUNT,
`endif
  output logic [CNT_W-1:0] CYCLE_COUNT
);

  localparam int unsigned HoldW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [HoldW-1:0] HoldInit = HoldW'(RST_CYCLES);
  localparam logic [CNT_W-1:0] LastRunCnt = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StResetHold, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef OTTER_RUN_WRCOUNT_EN
  logic [15:0]      wr_q, wr_d;
`endif

  logic halt_wr;
  logic last_run;

  assign halt_wr  = IOBUS_WR && (IOBUS_ADDR == HALT_ADDR);
  // cnt_q still holds k-1 during RUN cycle k
  assign last_run = (cnt_q == LastRunCnt);

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= '0;
      cnt_q     <= '0;
`ifdef OTTER_RUN_WRCOUNT_EN
      wr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
`ifdef OTTER_RUN_WRCOUNT_EN
      wr_q      <= wr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (START) state_d = StResetHold;
      StResetHold:    if (hold_q == HoldW'(1)) state_d = StRun;
      StRun:          if (halt_wr || last_run) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    hold_d    = hold_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
`ifdef OTTER_RUN_WRCOUNT_EN
    wr_d      = wr_q;
`endif
    // Processor runs only while the next state is RUN, so it freezes right after a verdict
    cpu_rst_d = (state_d != StRun);
    busy_d    = (state_d == StResetHold) || (state_d == StRun);

    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          hold_d    = HoldInit;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          result_d  = '0;
          cnt_d     = '0;
`ifdef OTTER_RUN_WRCOUNT_EN
          wr_d      = '0;
`endif
        end
      end
      StResetHold: begin
        hold_d = hold_q - HoldW'(1);
      end
      StRun: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef OTTER_RUN_WRCOUNT_EN
        if (IOBUS_WR && (wr_q != 16'hFFFF)) wr_d = wr_q + 16'd1;
`endif
        // Halt write wins over a timeout in the final budget cycle
        if (halt_wr) begin
          result_d = IOBUS_OUT;
          pass_d   = (IOBUS_OUT == PASS_VALUE);
          fail_d   = (IOBUS_OUT != PASS_VALUE);
          done_d   = 1'b1;
        end else if (last_run) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign CPU_RST     = cpu_rst_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign PASS        = pass_q;
  assign FAIL        = fail_q;
  assign TIMEOUT     = timeout_q;
  assign RESULT      = result_q;
  assign CYCLE_COUNT = cnt_q;
`ifdef OTTER_RUN_WRCOUNT_EN
  assign WR_COUNT    = wr_q;
`endif

endmodule

// File: doc/otter_run_controller.md
Name: otter_run_controller

Overview:
- Synthesizable run/check controller that drives the OTTER processor reset and watches its IOBUS for an end-of-test write.
- Parametrised successor of our fixed-delay processor bench: reset length, run budget, halt address and pass signature are all configurable.
- Adds pass/fail/timeout verdicts and a run-cycle counter, so the same block serves simulation and on-board self-test.
- Sits beside OTTER_PROCESSOR: it sources the processor RST and snoops IOBUS_ADDR/IOBUS_OUT/IOBUS_WR.

Parameters:
RST_CYCLES, 2, cycles CPU_RST is held high after START; legal range is 1 or more.
MAX_CYCLES, 50, run budget in RUN cycles before a timeout; legal range is 1 or more.
HALT_ADDR, 32'h1100_00F0, IOBUS address that ends the test.
PASS_VALUE, 32'h0000_0001, data written to HALT_ADDR that means pass.
CNT_W, 32, width of CYCLE_COUNT; must hold MAX_CYCLES.

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  single-cycle request to begin a run
IOBUS_ADDR  in  32  processor IOBUS address
IOBUS_OUT  in  32  processor IOBUS write data
IOBUS_WR  in  1  processor IOBUS write strobe
CPU_RST  out  1  active-high reset to the processor
BUSY  out  1  high in RESET_HOLD and RUN
DONE  out  1  sticky: a verdict is available
PASS  out  1  sticky: halt write data equalled PASS_VALUE
FAIL  out  1  sticky: halt write data differed from PASS_VALUE
TIMEOUT  out  1  sticky: budget exhausted with no halt write
RESULT  out  32  data captured from the halt write
CYCLE_COUNT  out  CNT_W  RUN cycles elapsed

Behaviour:
- States are IDLE, RESET_HOLD, RUN and DONE. All outputs are registered.
- Reset with RST_N=0 (asynchronous):
  - state=IDLE, CPU_RST=1, BUSY=0.
  - DONE, PASS, FAIL and TIMEOUT are 0.
  - RESULT=0 and CYCLE_COUNT=0.
- IDLE:
  - CPU_RST=1.
  - START=1 moves to RESET_HOLD on the next edge.
  - That edge also clears DONE, PASS, FAIL, TIMEOUT, RESULT and CYCLE_COUNT, and loads the hold counter.
- RESET_HOLD:
  - CPU_RST=1 for exactly RST_CYCLES cycles, then the state moves to RUN.
  - CPU_RST becomes 0 in the first RUN cycle.
  - IOBUS activity is ignored.
- RUN:
  - CPU_RST=0. CYCLE_COUNT increments on each RUN-cycle edge.
  - A halt write in RUN cycle k (1-based) leaves CYCLE_COUNT=k.
  - Halt write means IOBUS_WR=1 and IOBUS_ADDR==HALT_ADDR (exact 32-bit compare). On the edge that samples it:
    - RESULT is loaded with IOBUS_OUT.
    - PASS is set if the data equals PASS_VALUE; otherwise FAIL is set.
    - DONE=1 and the state moves to DONE.
  - A write to any other address has no effect.
  - Timeout: if RUN cycle MAX_CYCLES ends with no halt write, TIMEOUT=1, DONE=1, the state moves to DONE and CYCLE_COUNT=MAX_CYCLES.
  - A halt write in cycle MAX_CYCLES takes priority over the timeout: TIMEOUT=0.
- DONE:
  - CPU_RST=1, so the processor is frozen from the cycle after the verdict.
  - Verdict outputs hold.
  - START=1 starts a new run exactly as from IDLE, with all flags cleared on that edge.
- START is ignored in RESET_HOLD and RUN; no restart happens mid-run.
- Exactly one of PASS, FAIL or TIMEOUT is set whenever DONE=1.
- Latency:
  - START edge to CPU_RST falling is RST_CYCLES cycles.
  - Halt-write edge to DONE visible is 0 cycles after that edge, i.e. registered on it.
- If RST_N is asserted mid-run, the block returns to IDLE immediately and CPU_RST=1 asynchronously.

Optional Feature:
- Macro: OTTER_RUN_WRCOUNT_EN.
- When defined:
  - Adds output WR_COUNT (16 bits), which counts every IOBUS_WR=1 cycle in RUN, including the halt write.
  - WR_COUNT saturates at 16'hFFFF, clears on the START edge, and resets to 0.
- When undefined: the port and counter do not exist and all other behaviour is identical.

Test Plan:
- Reset, then START at cycle 0 with defaults -> CPU_RST stays 1 for 2 cycles, falls in the 3rd cycle, BUSY=1 from the cycle after START.
- In RUN cycle 10, write 32'h1 to 32'h1100_00F0 -> next cycle DONE=1, PASS=1, FAIL=0, RESULT=32'h1, CYCLE_COUNT=10, CPU_RST=1.
- Halt write of 32'hDEAD_BEEF in RUN cycle 5 -> DONE=1, FAIL=1, PASS=0, RESULT=32'hDEAD_BEEF.
- No halt write with MAX_CYCLES=50 -> after RUN cycle 50, TIMEOUT=1, DONE=1, CYCLE_COUNT=50.
  - Rerun with the halt write in RUN cycle 50 -> PASS=1 and TIMEOUT=0.
- START pulsed in RUN cycle 3 is ignored. Write to 32'h1100_00F4 is ignored. RST_N pulled low in RUN cycle 7 -> immediately CPU_RST=1 and all flags 0. A new START after reset gives a normal run.
- With OTTER_RUN_WRCOUNT_EN: 3 non-halt writes then a halt write -> WR_COUNT=4. A new START -> WR_COUNT=0.
